reorder_buffer: RTL

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: rename allocates at the tail, execution marks entries done
// out of order, and the head retires one entry per cycle; a retiring mispredict flushes everything.
module reorder_buffer #(
    parameter int ROB_ENTRY    = 16,
    parameter int NUM_ARCH_REG = 16,
    parameter int NUM_PHYS_REG = 128,
    parameter int WORD_SIZE_P  = 16
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            rename_rob_v_i,
    input  logic [WORD_SIZE_P-1:0]          alloc_pc_i,
    input  logic                            alloc_w_v_i,
    input  logic [$clog2(NUM_ARCH_REG)-1:0] alloc_arch_reg_i,
    input  logic [$clog2(NUM_PHYS_REG)-1:0] alloc_freed_reg_i,
    input  logic                            alloc_is_store_i,
    output logic                            rob_ready_o,
    output logic [$clog2(ROB_ENTRY)-1:0]    rob_num_o,
    input  logic                            wb_v_i,
    input  logic [$clog2(ROB_ENTRY)-1:0]    wb_rob_i,
    input  logic                            wb_mispredict_i,
    input  logic [WORD_SIZE_P-1:0]          wb_resolved_pc_i,
    output logic                            commit_v_o,
    output logic                            commit_w_v_o,
    output logic [$clog2(NUM_ARCH_REG)-1:0] commit_alloc_reg_o,
    output logic [$clog2(NUM_PHYS_REG)-1:0] commit_freed_reg_o,
    output logic                            commit_is_store_o,
    output logic                            mispredict_o,
    output logic [WORD_SIZE_P-1:0]          redirect_pc_o
);
    localparam int IDX_W = $clog2(ROB_ENTRY);
    localparam int CNT_W = IDX_W + 1;
    localparam int AR_W  = $clog2(NUM_ARCH_REG);
    localparam int PR_W  = $clog2(NUM_PHYS_REG);

    typedef struct packed {
        logic                   valid;
        logic                   done;
        logic                   mispredict;
        logic [WORD_SIZE_P-1:0] resolved_pc;
        logic                   w_v;
        logic [AR_W-1:0]        arch_reg;
        logic [PR_W-1:0]        freed_reg;
        logic                   is_store;
    } entry_t;

    entry_t [ROB_ENTRY-1:0] rob_q, rob_d;
    logic   [IDX_W-1:0]     head_q, head_d, tail_q, tail_d;
    logic   [CNT_W-1:0]     count_q, count_d;

    entry_t head_e;
    logic   commit_v, flush, alloc_fire;

    // The PC travels with the instruction for tracing only; no retirement field depends on it.
    logic unused_pc;
    assign unused_pc = ^alloc_pc_i;

    assign head_e     = rob_q[head_q];
    assign commit_v   = head_e.valid && head_e.done;
    assign flush      = commit_v && head_e.mispredict;
    assign rob_ready_o = (count_q != CNT_W'(ROB_ENTRY));
    assign alloc_fire = rename_rob_v_i && rob_ready_o && !flush;
    assign rob_num_o  = tail_q;

    assign commit_v_o         = commit_v;
    assign commit_w_v_o       = commit_v && head_e.w_v;
    assign commit_alloc_reg_o = commit_v ? head_e.arch_reg : '0;
    assign commit_freed_reg_o = commit_v ? head_e.freed_reg : '0;
    assign commit_is_store_o  = commit_v && head_e.is_store;
    assign mispredict_o       = flush;
    assign redirect_pc_o      = flush ? head_e.resolved_pc : '0;

    always_comb begin
        rob_d   = rob_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (wb_v_i && rob_q[wb_rob_i].valid) begin
            rob_d[wb_rob_i].done        = 1'b1;
            rob_d[wb_rob_i].mispredict  = wb_mispredict_i;
            rob_d[wb_rob_i].resolved_pc = wb_resolved_pc_i;
        end

        if (commit_v) begin
            rob_d[head_q].valid = 1'b0;
            rob_d[head_q].done  = 1'b0;
            head_d = head_q + 1'b1;
        end

        // The tail slot is never valid when allocation fires, so it cannot collide with a writeback.
        if (alloc_fire) begin
            rob_d[tail_q] = '{valid: 1'b1, done: 1'b0, mispredict: 1'b0, resolved_pc: '0,
                              w_v: alloc_w_v_i, arch_reg: alloc_arch_reg_i,
                              freed_reg: alloc_freed_reg_i, is_store: alloc_is_store_i};
            tail_d = tail_q + 1'b1;
        end

        case ({alloc_fire, commit_v})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (flush) begin
            for (int i = 0; i < ROB_ENTRY; i++) begin
                rob_d[i].valid = 1'b0;
                rob_d[i].done  = 1'b0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rob_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            rob_q   <= rob_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule
